time_counter_gen: RTL and testbench



---
 rtl/time_counter_gen_if.sv | 32 +++
 rtl/time_counter_gen.sv | 144 ++++++++++++++
 tb/tb_time_counter_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/time_counter_gen_if.sv
//------------------------------------------------------------------------------
// time_counter_gen_if : control/time bus between the tick/set logic and the
//                       time-of-day counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface time_counter_gen_if;
  logic        CE;
  logic        SETH;
  logic        SETM;
  logic        DOWN;
  logic        SCLR;
  logic        LOAD;
  logic [23:0] LOAD_TIME;
  logic        MODE12;
  logic [31:0] TIME;
  logic        PM;
  logic        DAYUP;

  modport master (
    output CE, SETH, SETM, DOWN, SCLR, LOAD, LOAD_TIME, MODE12,
    input  TIME, PM, DAYUP
  );

  modport slave (
    input  CE, SETH, SETM, DOWN, SCLR, LOAD, LOAD_TIME, MODE12,
    output TIME, PM, DAYUP
  );
endinterface

`default_nettype wire

// File: rtl/time_counter_gen.sv
//------------------------------------------------------------------------------
// time_counter_gen : cascaded BCD hh:mm:ss:uu time-of-day counter with set
//                    stepping, load, 12-hour view and day-rollover pulse.
//                    Optional macro SET_ACCEL_EN enables set-step acceleration.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module time_counter_gen #(
  parameter int FRAC_MOD = 100,
  parameter int SET_HOLD = 4
) (
  input wire logic           CLK,
  input wire logic           RST,
  time_counter_gen_if.slave  tcg
);

  localparam logic [7:0] c_uu_max = (FRAC_MOD == 10) ? 8'h09 : 8'h99;
  localparam logic [7:0] c_ms_max = 8'h59;
  localparam logic [7:0] c_hh_max = 8'h23;

  if (!(FRAC_MOD == 10 || FRAC_MOD == 100) || SET_HOLD < 1) begin : g_param_err
    $error("time_counter_gen: illegal FRAC_MOD or SET_HOLD");
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)          return 8'h00;
    else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                    return v + 8'h01;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00)          return vmax;
    else if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    else                     return v - 8'h01;
  endfunction

  function automatic logic [7:0] bcd_valid(input logic [7:0] v, input logic [7:0] vmax);
    if (v[7:4] > 4'h9 || v[3:0] > 4'h9 || v > vmax) return 8'h00;
    else                                            return v;
  endfunction

  logic [7:0] r_uu, r_ss, r_mm, r_hh;
  logic       r_dayup;
  logic [7:0] w_uu_n, w_ss_n, w_mm_n, w_hh_n;
  logic       w_ces, w_cem, w_ceh;
  logic       w_set, w_step_tick, w_step, w_dayup_n;

  assign w_ces = tcg.CE && (r_uu == c_uu_max);
  assign w_cem = w_ces && (r_ss == c_ms_max);
  assign w_ceh = w_cem && (r_mm == c_ms_max);
  assign w_set = tcg.SETH || tcg.SETM;

`ifdef SET_ACCEL_EN
  localparam int REP_W = $clog2(SET_HOLD + 1);
  logic [REP_W-1:0] r_rep;
  logic             w_fast;
  logic             w_fast_tick;

  assign w_fast      = (r_rep == REP_W'(SET_HOLD));
  // 10x speed: one step per tenth of a second
  assign w_fast_tick = (FRAC_MOD == 100) ? (tcg.CE && (r_uu[3:0] == 4'h9)) : tcg.CE;
  assign w_step_tick = w_fast ? w_fast_tick : w_ces;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          r_rep <= '0;
    else if (tcg.LOAD || !w_set)      r_rep <= '0;
    else if (w_step && !w_fast)       r_rep <= r_rep + 1'b1;
  end
`else
  assign w_step_tick = w_ces;
`endif

  assign w_step = w_step_tick && w_set;

  always_comb begin
    w_uu_n    = r_uu;
    w_ss_n    = r_ss;
    w_mm_n    = r_mm;
    w_hh_n    = r_hh;
    w_dayup_n = 1'b0;
    if (tcg.LOAD) begin
      w_uu_n = 8'h00;
      w_ss_n = bcd_valid(tcg.LOAD_TIME[7:0],   c_ms_max);
      w_mm_n = bcd_valid(tcg.LOAD_TIME[15:8],  c_ms_max);
      w_hh_n = bcd_valid(tcg.LOAD_TIME[23:16], c_hh_max);
    end else if (tcg.SCLR) begin
      w_uu_n = 8'h00;
      w_ss_n = 8'h00;
    end else begin
      if (tcg.CE) w_uu_n = bcd_inc(r_uu, c_uu_max);
      if (w_ces)  w_ss_n = bcd_inc(r_ss, c_ms_max);
      // a held set line replaces the natural carry into its field and above
      if (tcg.SETM) begin
        if (w_step) w_mm_n = tcg.DOWN ? bcd_dec(r_mm, c_ms_max) : bcd_inc(r_mm, c_ms_max);
      end else if (w_cem) begin
        w_mm_n = bcd_inc(r_mm, c_ms_max);
      end
      if (tcg.SETH) begin
        if (w_step) w_hh_n = tcg.DOWN ? bcd_dec(r_hh, c_hh_max) : bcd_inc(r_hh, c_hh_max);
      end else if (w_ceh && !tcg.SETM) begin
        w_hh_n    = bcd_inc(r_hh, c_hh_max);
        w_dayup_n = (r_hh == c_hh_max);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_uu    <= 8'h00;
      r_ss    <= 8'h00;
      r_mm    <= 8'h00;
      r_hh    <= 8'h00;
      r_dayup <= 1'b0;
    end else begin
      r_uu    <= w_uu_n;
      r_ss    <= w_ss_n;
      r_mm    <= w_mm_n;
      r_hh    <= w_hh_n;
      r_dayup <= w_dayup_n;
    end
  end

  logic [4:0] w_hbin, w_h12bin;
  logic [7:0] w_h12, w_hdisp;

  always_comb begin
    w_hbin   = 5'(r_hh[7:4]) * 5'd10 + 5'(r_hh[3:0]);
    w_h12bin = w_hbin - 5'd12;
    w_h12    = (w_h12bin >= 5'd10) ? {4'h1, 4'(w_h12bin - 5'd10)} : {4'h0, w_h12bin[3:0]};
    w_hdisp  = r_hh;
    if (tcg.MODE12) begin
      if (r_hh == 8'h00 || r_hh == 8'h12) w_hdisp = 8'h12;
      else if (r_hh > 8'h12)              w_hdisp = w_h12;
    end
  end

  assign tcg.TIME  = {w_hdisp, r_mm, r_ss, r_uu};
  assign tcg.PM    = (r_hh >= 8'h12);
  assign tcg.DAYUP = r_dayup;

endmodule

`default_nettype wire

// File: tb/tb_time_counter_gen.sv
//------------------------------------------------------------------------------
// tb_time_counter_gen : directed self-checking bench for time_counter_gen.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_time_counter_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  time_counter_gen_if bus();

  time_counter_gen #(.FRAC_MOD(100), .SET_HOLD(4)) dut (
    .CLK (clk),
    .RST (rst),
    .tcg (bus)
  );

  int total = 0;
  int bad   = 0;
  int dayups = 0;

  typedef struct {
    logic [23:0] ld;
    logic        m12;
    logic [31:0] t;
    logic        pm;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.DAYUP) dayups++;
  endtask

  task automatic run_ce(input int n);
    bus.CE = 1'b1;
    repeat (n) step();
    bus.CE = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] v);
    bus.LOAD_TIME = v;
    bus.LOAD      = 1'b1;
    step();
    bus.LOAD      = 1'b0;
  endtask

  task automatic set_run(input string name, input logic [23:0] ld, input logic seth,
                         input logic setm, input logic down, input logic [31:0] exp);
    do_load(ld);
    bus.SETH = seth;
    bus.SETM = setm;
    bus.DOWN = down;
    dayups   = 0;
    run_ce(100);
    bus.SETH = 1'b0;
    bus.SETM = 1'b0;
    bus.DOWN = 1'b0;
    chk(name, bus.TIME, exp);
    chk({name, "_dayup"}, 32'(dayups), 32'd0);
  endtask

  initial begin
    logic [7:0] prev_ss;
    int         ss_chg;

    vecs[0] = '{24'h000000, 1'b1, 32'h12000000, 1'b0};
    vecs[1] = '{24'h134500, 1'b1, 32'h01450000, 1'b1};
    vecs[2] = '{24'h120000, 1'b1, 32'h12000000, 1'b1};
    vecs[3] = '{24'h235959, 1'b1, 32'h11595900, 1'b1};
    vecs[4] = '{24'h095900, 1'b1, 32'h09590000, 1'b0};
    vecs[5] = '{24'h200000, 1'b1, 32'h08000000, 1'b1};
    vecs[6] = '{24'h134500, 1'b0, 32'h13450000, 1'b1};
    vecs[7] = '{24'h2A7999, 1'b0, 32'h00000000, 1'b0};
    vecs[8] = '{24'h1A3060, 1'b0, 32'h00300000, 1'b0};
    vecs[9] = '{24'h246000, 1'b0, 32'h00000000, 1'b0};

    bus.CE = 1'b0; bus.SETH = 1'b0; bus.SETM = 1'b0; bus.DOWN = 1'b0;
    bus.SCLR = 1'b0; bus.LOAD = 1'b0; bus.LOAD_TIME = 24'h0; bus.MODE12 = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset_time",  bus.TIME, 32'h00000000);
    chk("reset_pm",    32'(bus.PM), 32'd0);
    chk("reset_dayup", 32'(bus.DAYUP), 32'd0);
    rst = 1'b0;
    step();

    // 100 fraction ticks make exactly one second
    prev_ss = bus.TIME[15:8];
    ss_chg  = 0;
    bus.CE  = 1'b1;
    repeat (100) begin
      step();
      if (bus.TIME[15:8] != prev_ss) ss_chg++;
      prev_ss = bus.TIME[15:8];
    end
    bus.CE = 1'b0;
    chk("count_100", bus.TIME, 32'h00000100);
    chk("ces_once",  32'(ss_chg), 32'd1);

    // day rollover
    do_load(24'h235958);
    chk("load_2359", bus.TIME, 32'h23595800);
    chk("load_pm",   32'(bus.PM), 32'd1);
    dayups = 0;
    run_ce(200);
    chk("wrap_time",  bus.TIME, 32'h00000000);
    chk("wrap_dayup_count", 32'(dayups), 32'd1);
    step();
    chk("dayup_drop", 32'(bus.DAYUP), 32'd0);
    chk("wrap_pm",    32'(bus.PM), 32'd0);

    // set stepping overrides the natural carry and never wraps the day
    set_run("setm_down",  24'h105959, 1'b0, 1'b1, 1'b1, 32'h10580000);
    set_run("seth_up",    24'h235000, 1'b1, 1'b0, 1'b0, 32'h00500100);
    set_run("seth_down",  24'h000000, 1'b1, 1'b0, 1'b1, 32'h23000100);
    set_run("setm_up",    24'h125900, 1'b0, 1'b1, 1'b0, 32'h12000100);
    set_run("setm_2359",  24'h235959, 1'b0, 1'b1, 1'b0, 32'h23000000);
    set_run("both_2359",  24'h235959, 1'b1, 1'b1, 1'b0, 32'h00000000);

    // load validation and 12-hour view
    for (int i = 0; i < 10; i++) begin
      bus.MODE12 = vecs[i].m12;
      do_load(vecs[i].ld);
      chk($sformatf("vec%0d_time", i), bus.TIME, vecs[i].t);
      chk($sformatf("vec%0d_pm", i), 32'(bus.PM), 32'(vecs[i].pm));
    end
    bus.MODE12 = 1'b0;

    // SCLR coinciding with the carry that would bump minutes
    do_load(24'h125959);
    run_ce(99);
    chk("pre_sclr", bus.TIME, 32'h12595999);
    bus.CE   = 1'b1;
    bus.SCLR = 1'b1;
    step();
    bus.CE   = 1'b0;
    bus.SCLR = 1'b0;
    chk("sclr_hold_mm", bus.TIME, 32'h12590000);

    // LOAD wins over SCLR
    bus.LOAD_TIME = 24'h081530;
    bus.LOAD = 1'b1;
    bus.SCLR = 1'b1;
    step();
    bus.LOAD = 1'b0;
    bus.SCLR = 1'b0;
    chk("load_over_sclr", bus.TIME, 32'h08153000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
